dmem_access_unit: RTL

Initiator-side data-memory access unit for the pd4 core. Accepts one load/store request at a time from the execute/memory stage and drives the byte-addressable `memory` data port (`addr_i`, `data_i`, `read_en_i`, `write_en_i`; returns `data_o`, `data_vld_o`). Loads are returned sign- or zero-extended. Because the memory always writes four bytes at the given address, byte and halfword stores are performed as read-modify-write sequences.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_load_align.sv | 37 +++
 rtl/dmem_access_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the pd4 data-memory access unit.
package dmem_pkg;

  // Access size encoding as presented by the execute/memory stage.
  // 2'b11 has no name on purpose: it is the illegal size.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } dmem_state_e;

  // Start of the data-memory address space.
  localparam logic [31:0] DMEM_BASE = 32'h0100_0000;

  // Any encoding other than byte/half/word gets an error response.
  function automatic logic size_legal(input logic [1:0] size);
    return (size == MEM_BYTE) || (size == MEM_HALF) || (size == MEM_WORD);
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load extender and store merger. Purely combinational; the FSM picks
// which result to register depending on the access direction.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [DWIDTH-1:0] raw,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] ld_data,
  output logic [DWIDTH-1:0] st_data
);

  // Sign/zero-extend the low byte or halfword of the fetched word.
  always_comb begin
    ld_data = raw;
    case (size)
      MEM_BYTE: ld_data = {{(DWIDTH-8){raw[7] & ~unsigned_ld}}, raw[7:0]};
      MEM_HALF: ld_data = {{(DWIDTH-16){raw[15] & ~unsigned_ld}}, raw[15:0]};
      default:  ld_data = raw;
    endcase
  end

  // Memory always writes four bytes, so sub-word stores carry the
  // fetched upper bytes back unchanged.
  always_comb begin
    st_data = wdata;
    case (size)
      MEM_BYTE: st_data = {raw[DWIDTH-1:8],  wdata[7:0]};
      MEM_HALF: st_data = {raw[DWIDTH-1:16], wdata[15:0]};
      default:  st_data = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Initiator-side data-memory access unit: one load/store at a time,
// sub-word stores done as read-modify-write. All outputs registered.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  input  logic              mem_data_vld_i
);

  dmem_state_e       state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;

  logic [DWIDTH-1:0] ld_data;
  logic [DWIDTH-1:0] st_data;

  dmem_load_align #(.DWIDTH(DWIDTH)) u_align (
    .size        (size_q),
    .unsigned_ld (uns_q),
    .raw         (mem_data_i),
    .wdata       (wdata_q),
    .ld_data     (ld_data),
    .st_data     (st_data)
  );

  assign req_ready_o = (state == IDLE);

  // Request FSM; memory and response outputs are set on the edge that
  // enters the state they belong to, and cleared on the edge that leaves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= '0;
      rsp_err_o      <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
      mem_read_en_o  <= 1'b0;
      mem_write_en_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            if (!size_legal(req_size_i)) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end else if (!req_we_i || (req_size_i != MEM_WORD)) begin
              // Loads and sub-word stores both need the current word first.
              state         <= READ;
              mem_read_en_o <= 1'b1;
              mem_addr_o    <= req_addr_i;
            end else begin
              state          <= WRITE;
              mem_write_en_o <= 1'b1;
              mem_addr_o     <= req_addr_i;
              mem_data_o     <= req_wdata_i;
            end
          end
        end

        READ: begin
          if (mem_data_vld_i) begin
            mem_read_en_o <= 1'b0;
            if (we_q) begin
              state          <= WRITE;
              mem_write_en_o <= 1'b1;
              mem_addr_o     <= addr_q;
              mem_data_o     <= st_data;
            end else begin
              state       <= RESP;
              mem_addr_o  <= '0;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= ld_data;
              rsp_err_o   <= 1'b0;
            end
          end
        end

        WRITE: begin
          state          <= RESP;
          mem_write_en_o <= 1'b0;
          mem_addr_o     <= '0;
          mem_data_o     <= '0;
          rsp_valid_o    <= 1'b1;
          rsp_rdata_o    <= '0;
          rsp_err_o      <= 1'b0;
        end

        RESP: begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          rsp_rdata_o <= '0;
          rsp_err_o   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
